// File: rtl/echo_responder.sv
// echo_responder: FIFO-backed loopback responder. Every accepted request word
// comes back as a response word, in order, after at least one cycle. Also
// provides occupancy and handshake counters and a sticky request-side
// protocol-violation flag.
module echo_responder #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [WIDTH-1:0]         req_data,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              xfer_count,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  // ST_INIT holds req_ready low until the first edge after reset release.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [OW-1:0]     r_occ;
  logic [15:0]       r_xfer;
  logic              r_proto_err;
  logic              r_prev_stall;
  logic [WIDTH-1:0]  r_prev_data;

  logic              w_run;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_proto_hit;
  logic [OW-1:0]     w_occ_next;

  // Run-state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: leave ST_INIT on the first edge out of reset, then stay in ST_RUN.
  always_comb begin
    w_state_next = r_state;
    w_run        = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_state_next = ST_RUN;
      end
      ST_RUN: begin
        w_state_next = ST_RUN;
        w_run        = 1'b1;
      end
      default: begin
        w_state_next = ST_INIT;
      end
    endcase
  end

  // Handshake qualification; a flush cancels both sides for that cycle.
  always_comb begin
    w_full     = (r_occ == OW'(DEPTH));
    w_empty    = (r_occ == '0);
    req_ready  = w_run && !w_full;
    resp_valid = !w_empty;
    w_push     = req_valid && req_ready && !flush;
    w_pop      = resp_valid && resp_ready && !flush;
  end

  // Occupancy next value from the push/pop combination.
  always_comb begin
    w_occ_next = r_occ;
    if (flush) begin
      w_occ_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_occ_next = r_occ + OW'(1);
        2'b01:   w_occ_next = r_occ - OW'(1);
        default: w_occ_next = r_occ;
      endcase
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      r_occ <= w_occ_next;
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end
    end
  end

  // Payload storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= req_data;
    end
  end

  // Completed response handshake counter, free-running wrap at 16 bits.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_xfer <= '0;
    end else if (w_pop) begin
      r_xfer <= r_xfer + 16'd1;
    end
  end

  // A stalled request must be held with identical data until accepted.
  always_comb begin
    w_proto_hit = r_prev_stall && (!req_valid || (req_data != r_prev_data));
  end

  // Remember last cycle's stall condition and data; latch any violation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prev_stall <= 1'b0;
      r_prev_data  <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_prev_stall <= req_valid && !req_ready;
      r_prev_data  <= req_data;
      if (w_proto_hit) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // Output drive.
  always_comb begin
    resp_data  = r_mem[r_rd_ptr];
    occupancy  = r_occ;
    xfer_count = r_xfer;
    proto_err  = r_proto_err;
  end

endmodule

// File: tb/tb_echo_responder.sv
module tb_echo_responder;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        flush;
  logic [2:0]  occupancy;
  logic [15:0] xfer_count;
  logic        proto_err;

  int unsigned n_checks;
  int unsigned n_fail;

  echo_responder #(.WIDTH(16), .DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .flush      (flush),
    .occupancy  (occupancy),
    .xfer_count (xfer_count),
    .proto_err  (proto_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        rr;
    logic        fl;
    logic        e_rdy;
    logic        e_rv;
    logic [15:0] e_rd;
    logic [2:0]  e_occ;
    logic [15:0] e_x;
    logic        e_pe;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [15:0] d, input logic rr, input logic fl);
    @(negedge clock);
    req_valid  = v;
    req_data   = d;
    resp_ready = rr;
    flush      = fl;
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_rdy, input logic e_rv,
                         input logic [15:0] e_rd, input logic [2:0] e_occ,
                         input logic [15:0] e_x, input logic e_pe);
    chk({tag, ".req_ready"},  32'(req_ready),  32'(e_rdy));
    chk({tag, ".resp_valid"}, 32'(resp_valid), 32'(e_rv));
    if (e_rv) chk({tag, ".resp_data"}, 32'(resp_data), 32'(e_rd));
    chk({tag, ".occupancy"},  32'(occupancy),  32'(e_occ));
    chk({tag, ".xfer_count"}, 32'(xfer_count), 32'(e_x));
    chk({tag, ".proto_err"},  32'(proto_err),  32'(e_pe));
  endtask

  initial begin
    logic [15:0] exp_x;
    n_checks = 0;
    n_fail   = 0;

    //        v  data     rr fl  rdy rv  rd       occ x       pe
    tbl[0]  = '{1, 16'h04D2, 1, 0, 1, 1, 16'h04D2, 1, 16'd0, 0}; // single echo
    tbl[1]  = '{0, 16'h0000, 1, 0, 1, 0, 16'h0000, 0, 16'd1, 0};
    tbl[2]  = '{1, 16'h0001, 0, 0, 1, 1, 16'h0001, 1, 16'd1, 0}; // fill
    tbl[3]  = '{1, 16'h0002, 0, 0, 1, 1, 16'h0001, 2, 16'd1, 0};
    tbl[4]  = '{1, 16'h0003, 0, 0, 1, 1, 16'h0001, 3, 16'd1, 0};
    tbl[5]  = '{1, 16'h0004, 0, 0, 0, 1, 16'h0001, 4, 16'd1, 0};
    tbl[6]  = '{1, 16'h0005, 0, 0, 0, 1, 16'h0001, 4, 16'd1, 0}; // refused when full
    tbl[7]  = '{1, 16'h0005, 1, 0, 1, 1, 16'h0002, 3, 16'd2, 0}; // pop only, no pass-through
    tbl[8]  = '{1, 16'h0005, 1, 0, 1, 1, 16'h0003, 3, 16'd3, 0}; // push+pop
    tbl[9]  = '{0, 16'h0000, 1, 0, 1, 1, 16'h0004, 2, 16'd4, 0};
    tbl[10] = '{0, 16'h0000, 1, 0, 1, 1, 16'h0005, 1, 16'd5, 0};
    tbl[11] = '{0, 16'h0000, 1, 0, 1, 0, 16'h0000, 0, 16'd6, 0};
    tbl[12] = '{1, 16'h00A1, 0, 0, 1, 1, 16'h00A1, 1, 16'd6, 0}; // flush setup
    tbl[13] = '{1, 16'h00A2, 0, 0, 1, 1, 16'h00A1, 2, 16'd6, 0};
    tbl[14] = '{1, 16'h00A3, 0, 0, 1, 1, 16'h00A1, 3, 16'd6, 0};
    tbl[15] = '{1, 16'h00B0, 1, 1, 1, 0, 16'h0000, 0, 16'd6, 0}; // flush drops push+pop
    tbl[16] = '{0, 16'h0000, 1, 0, 1, 0, 16'h0000, 0, 16'd6, 0};

    reset      = 1'b0;
    req_valid  = 1'b0;
    req_data   = '0;
    resp_ready = 1'b0;
    flush      = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_all("reset", 1'b0, 1'b0, 16'h0, 3'd0, 16'd0, 1'b0);

    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(req_ready), 32'd0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk_all("first_edge", 1'b1, 1'b0, 16'h0, 3'd0, 16'd0, 1'b0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].rr, tbl[i].fl);
      chk_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_rv, tbl[i].e_rd,
              tbl[i].e_occ, tbl[i].e_x, tbl[i].e_pe);
    end

    // Streaming 0..99 with resp_ready held: one-deep, in order, pointers wrap.
    exp_x = 16'd6;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 16'(i), 1'b1, 1'b0);
      if (i > 0) exp_x = exp_x + 16'd1;
      chk($sformatf("stream%0d.occ", i), 32'(occupancy), 32'd1);
      chk($sformatf("stream%0d.data", i), 32'(resp_data), 32'(i));
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    exp_x = exp_x + 16'd1;
    chk_all("stream_end", 1'b1, 1'b0, 16'h0, 3'd0, exp_x, 1'b0);
    chk("stream_count", 32'(xfer_count), 32'd106);

    // Protocol error: stall with AAAA, then change data to 5555.
    step(1'b1, 16'h00E1, 1'b0, 1'b0);
    step(1'b1, 16'h00E2, 1'b0, 1'b0);
    step(1'b1, 16'h00E3, 1'b0, 1'b0);
    step(1'b1, 16'h00E4, 1'b0, 1'b0);
    chk_all("pe_full", 1'b0, 1'b1, 16'h00E1, 3'd4, exp_x, 1'b0);
    step(1'b1, 16'hAAAA, 1'b0, 1'b0);
    chk("pe_stall", 32'(proto_err), 32'd0);
    step(1'b1, 16'h5555, 1'b0, 1'b0);
    chk("pe_set", 32'(proto_err), 32'd1);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("pe_held", 32'(proto_err), 32'd1);

    // Async reset between edges with two words buffered.
    @(negedge clock);
    reset = 1'b0;
    #1;
    reset = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    step(1'b1, 16'h0C01, 1'b0, 1'b0);
    step(1'b1, 16'h0C02, 1'b0, 1'b0);
    chk_all("pre_areset", 1'b1, 1'b1, 16'h0C01, 3'd2, 16'd0, 1'b0);
    @(negedge clock);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk_all("areset", 1'b0, 1'b0, 16'h0, 3'd0, 16'd0, 1'b0);
    @(posedge clock);
    #1;
    chk_all("areset_hold", 1'b0, 1'b0, 16'h0, 3'd0, 16'd0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk_all("after_areset", 1'b1, 1'b0, 16'h0, 3'd0, 16'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/echo_responder.md
ECHO_RESPONDER -- requirements
Module: echo_responder

Interface
- REQ-001 SHALL have parameter WIDTH, default 16, meaning data width of request and response payloads.
- REQ-002 SHALL have parameter DEPTH, default 4, meaning echo buffer entries; power of two, minimum 2.
- REQ-003 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset: 0 resets immediately, 1 runs.
- REQ-005 SHALL have port req_valid, input, 1, tester presents a request word.
- REQ-006 SHALL have port req_ready, output, 1, responder can accept a request word this cycle.
- REQ-007 SHALL have port req_data, input, WIDTH, request payload.
- REQ-008 SHALL have port resp_valid, output, 1, a response word is presented.
- REQ-009 SHALL have port resp_ready, input, 1, tester accepts the response word this cycle.
- REQ-010 SHALL have port resp_data, output, WIDTH, response payload.
- REQ-011 SHALL have port flush, input, 1, synchronous discard of all buffered words.
- REQ-012 SHALL have port occupancy, output, log2(DEPTH)+1, words currently buffered.
- REQ-013 SHALL have port xfer_count, output, 16, number of completed response handshakes.
- REQ-014 SHALL have port proto_err, output, 1, sticky flag for request-side protocol violation.

Function
- REQ-015 SHALL accept a request when req_valid and req_ready are both 1 at a rising edge (push).
- REQ-016 SHALL complete a response when resp_valid and resp_ready are both 1 at a rising edge (pop).
- REQ-017 SHALL return every accepted word unmodified, in acceptance order, with no loss or duplication.
- REQ-018 SHALL drive req_ready = 1 exactly when occupancy < DEPTH; no full-state pass-through, so req_ready stays 0 when full even if a pop occurs that cycle.
- REQ-019 SHALL drive resp_valid = 1 exactly when occupancy > 0; resp_data = oldest buffered word.
- REQ-020 SHALL have minimum latency of one cycle: word pushed at edge N is visible on resp_data after edge N, never combinationally.
- REQ-021 SHALL, on simultaneous push and pop with 0 < occupancy < DEPTH, keep occupancy unchanged and advance both pointers.
- REQ-022 SHALL wrap read and write pointers modulo DEPTH without corrupting order.
- REQ-023 SHALL keep resp_data stable while resp_valid = 1 and resp_ready = 0.
- REQ-024 SHALL, when flush = 1 at an edge, set occupancy to 0 and ignore any push or pop in that cycle; xfer_count unaffected.
- REQ-025 SHALL increment xfer_count by 1 per pop, wrapping 16'hFFFF -> 16'h0000.
- REQ-026 SHALL set proto_err when req_valid was 1 and req_ready was 0 in the previous cycle and, in the current cycle, req_valid = 0 or req_data differs from the previous value; proto_err stays 1 until reset.
- REQ-027 SHALL ignore req_data and resp_ready values when the paired valid is 0 (no state change).

Reset
- REQ-028 SHALL, while reset = 0, force occupancy = 0, xfer_count = 0, proto_err = 0, req_ready = 0, resp_valid = 0, pointers = 0.
- REQ-029 SHALL, on reset assertion mid-operation, discard all buffered words immediately; no response completes after assertion.
- REQ-030 SHALL raise req_ready to 1 on the first rising edge after reset deasserts; resp_data value is don't-care while resp_valid = 0.

Verification
- REQ-031 Single echo: push 16'h04D2 with resp_ready = 1 -> resp_valid high next cycle, resp_data = 16'h04D2, xfer_count = 1.
- REQ-032 Fill: resp_ready = 0, push 16'h0001..16'h0005 -> first four accepted, req_ready = 0 after fourth, occupancy = 4; then drain -> 0001,0002,0003,0004 in order.
- REQ-033 Wrap/streaming: 100 back-to-back words 0..99 with resp_ready = 1 continuously -> all returned in order, occupancy never exceeds 1, xfer_count = 100.
- REQ-034 Flush: occupancy = 3, flush = 1 with req_valid = 1 -> next cycle occupancy = 0, resp_valid = 0, pushed word dropped, xfer_count unchanged.
- REQ-035 Protocol error: full buffer, req_valid = 1 with 16'hAAAA, next cycle req_data = 16'h5555 -> proto_err = 1 and held until reset.
- REQ-036 Async reset: reset = 0 asserted between edges with occupancy = 2 -> occupancy = 0, resp_valid = 0, req_ready = 0 before the next edge.
